traffic_intersection_ctrl: RTL
==============================

# traffic_intersection_ctrl

Parametrised two-road intersection controller that grants right-of-way between a highway and a country road. It is the next-generation signal controller: a fully synthesizable Moore FSM driven by a dwell counter, with no event-control delays inside the logic. It adds configurable yellow and all-red intervals, a minimum green on both roads, and a maximum country green. It sits directly behind the road sensor input and drives the two lamp-driver buses.

## Interface
- `Y2R_CYCLES`, default 3: yellow duration in cycles, ≥1.
- `R2G_CYCLES`, default 2: all-red clearance duration in cycles, ≥1.
- `MIN_GREEN`, default 4: minimum green dwell on either road, ≥1.
- `MAX_CNTRY_GREEN`, default 8: forced end of country green, ≥ `MIN_GREEN`.
- `CNT_W`, default 4: dwell counter width; must satisfy 2^`CNT_W`−1 ≥ max(all durations).
- `clock`  in  1: single clock; all state updates occur on its rising edge.
- `clear`  in  1: synchronous, active-high reset.
- `X`  in  1: car present on the country road; sampled at `clock` edges.
- `hwy`  out  2: highway lamp, RED=0, YELLOW=1, GREEN=2.
- `cntry`  out  2: country lamp, same encoding as `hwy`.
- `phase`  out  3: current FSM state, for debug and visibility.

## Operation
- States:
  - HG: hwy GREEN, cntry RED.
  - HY: hwy YELLOW, cntry RED.
  - RR1: both RED.
  - CG: hwy RED, cntry GREEN.
  - CY: hwy RED, cntry YELLOW.
  - RR2: both RED.
- State encoding is 0 to 5 in the order listed.
- `cnt` is the dwell counter.
  - It is 0 in the first cycle of every state.
  - It increments every cycle the state is held and saturates at all-ones.
- Transitions, evaluated at each edge:
  - HG→HY when `X` && `cnt` ≥ `MIN_GREEN`−1.
  - HY→RR1 when `cnt` == `Y2R_CYCLES`−1.
  - RR1→CG when `cnt` == `R2G_CYCLES`−1.
  - CG→CY when (!`X` && `cnt` ≥ `MIN_GREEN`−1) \|\| `cnt` == `MAX_CNTRY_GREEN`−1.
  - CY→RR2 when `cnt` == `Y2R_CYCLES`−1.
  - RR2→HG when `cnt` == `R2G_CYCLES`−1.
- Illegal encodings (6, 7) go to HG on the next edge.
- The highway never yields before `MIN_GREEN` cycles of green. The country road never holds green beyond `MAX_CNTRY_GREEN` cycles even if `X` stays high.
- No state ever shows GREEN or YELLOW on both roads at once.

## Timing
- Reset: `clear`=1 at an edge forces state HG and `cnt`=0.
  - Outputs after that edge: `hwy`=2, `cntry`=0, `phase`=0.
  - `clear` takes priority over every transition, including when asserted mid-yellow or mid-all-red.
- `hwy`, `cntry` and `phase` are pure decodes of the registered state. They change in the cycle after the edge at which a transition condition is true, so latency from sampled `X` to lamp change is 1 cycle.
- Durations in cycles:
  - HY, CY: exactly `Y2R_CYCLES`.
  - RR1, RR2: exactly `R2G_CYCLES`.
  - HG: ≥ `MIN_GREEN`.
  - CG: `MIN_GREEN` to `MAX_CNTRY_GREEN`.
- `X` is ignored in HY, RR1, CY and RR2.

## Configuration
- `PED_REQ_EN` defined:
  - Adds input `ped_req` (1 bit) and output `walk` (1 bit).
  - A `ped_req` pulse sets a sticky `ped_pend` bit (reset 0).
  - The HG exit condition uses (`X` \|\| `ped_pend`) in place of `X`.
  - `ped_pend` clears on entry to CG.
  - `walk`=1 exactly while in CG; reset value is 0.
- `PED_REQ_EN` undefined: neither port exists, and behaviour is exactly as described above.

## Structure
- Shared package `traffic_pkg` holds:
  - Lamp encodings RED, YELLOW, GREEN (2-bit).
  - State enum for HG, HY, RR1, CG, CY, RR2 (3-bit).
- One sub-module, `dwell_timer`: a saturating `CNT_W`-bit counter with synchronous `clear` and a restart input pulsed on every state change. Its output is `cnt`.

## Test plan
All scenarios use default parameters.
1. Hold `clear` high for 2 cycles with `X`=0 → `hwy`=2, `cntry`=0, `phase`=0, and these stay stable for 20 cycles after release.
2. Raise `X` one cycle after reset release → HG lasts 4 cycles, then HY 3, RR1 2, then CG (`cntry`=2).
3. Hold `X` high continuously → CG lasts exactly 8 cycles, then CY 3, RR2 2, HG 4, then HY again.
4. `X` drops in the second CG cycle → CG lasts exactly 4 cycles, then CY.
5. Assert `clear` in the second RR1 cycle → next cycle `phase`=0, `hwy`=2, `cntry`=0, `cnt`=0.
6. With `PED_REQ_EN`: 1-cycle `ped_req` pulse with `X`=0 while HG has `cnt`=6 → HY next cycle; `walk`=1 for 4 CG cycles; `ped_pend` is 0 afterwards.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp encodings and controller state enum for the two-road intersection.
// Used by traffic_intersection_ctrl and its dwell_timer.
package traffic_pkg;

    typedef logic [1:0] lamp_t;

    localparam lamp_t RED    = 2'd0;
    localparam lamp_t YELLOW = 2'd1;
    localparam lamp_t GREEN  = 2'd2;

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        RR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        RR2 = 3'd5
    } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Saturating dwell counter: zero in the first cycle of every state, then counts
// up each held cycle and sticks at all-ones.
module dwell_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             restart,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clock) begin
        if (clear || restart) begin
            cnt_reg <= '0;
        end else if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Highway / country road right-of-way controller: Moore FSM timed by dwell_timer.
// Optional pedestrian request path is enabled by defining PED_REQ_EN.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int Y2R_CYCLES      = 3,
    parameter int R2G_CYCLES      = 2,
    parameter int MIN_GREEN       = 4,
    parameter int MAX_CNTRY_GREEN = 8,
    parameter int CNT_W           = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       X,
`ifdef PED_REQ_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] Y2R_LAST  = CNT_W'(Y2R_CYCLES - 1);
    localparam logic [CNT_W-1:0] R2G_LAST  = CNT_W'(R2G_CYCLES - 1);
    localparam logic [CNT_W-1:0] MING_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAXC_LAST = CNT_W'(MAX_CNTRY_GREEN - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             restart;
    logic             hg_req;

    dwell_timer #(
        .CNT_W(CNT_W)
    ) u_dwell_timer (
        .clock  (clock),
        .clear  (clear),
        .restart(restart),
        .cnt    (cnt)
    );

`ifdef PED_REQ_EN
    logic ped_pend_reg;

    // A request arriving this cycle counts immediately, not one cycle late.
    assign hg_req = X | ped_pend_reg | ped_req;

    always_ff @(posedge clock) begin
        if (clear) begin
            ped_pend_reg <= 1'b0;
        end else if (ped_req) begin
            ped_pend_reg <= 1'b1;
        end else if (state_next == CG && state_reg != CG) begin
            ped_pend_reg <= 1'b0;
        end
    end

    assign walk = (state_reg == CG);
`else
    assign hg_req = X;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= HG;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            HG:  if (hg_req && cnt >= MING_LAST) state_next = HY;
            HY:  if (cnt == Y2R_LAST)            state_next = RR1;
            RR1: if (cnt == R2G_LAST)            state_next = CG;
            CG:  if ((!X && cnt >= MING_LAST) || cnt == MAXC_LAST) state_next = CY;
            CY:  if (cnt == Y2R_LAST)            state_next = RR2;
            RR2: if (cnt == R2G_LAST)            state_next = HG;
            default:                             state_next = HG;
        endcase
    end

    // Illegal encodings also restart the timer since they always move to HG.
    assign restart = (state_next != state_reg);

    always_comb begin
        hwy   = RED;
        cntry = RED;
        case (state_reg)
            HG:      hwy   = GREEN;
            HY:      hwy   = YELLOW;
            CG:      cntry = GREEN;
            CY:      cntry = YELLOW;
            default: begin
                hwy   = RED;
                cntry = RED;
            end
        endcase
    end

    assign phase = state_reg;

endmodule
